uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
Receive-side frame parser that sits directly downstream of a COREUART receiver instance. It pops bytes from the UART RX FIFO using the RXRDY/OEN handshake and hunts for a two-byte header. It then collects a length-prefixed payload and verifies an 8-bit additive checksum. Only validated payloads are presented to the consuming control block over a valid/ready byte stream; malformed, corrupt or stalled frames are discarded and flagged.

Parameters:
MAX_LEN, 32, maximum payload bytes per frame (1..255); also the depth of the internal buffer
TIMEOUT_CYC, 40000, CLK cycles allowed between consecutive bytes inside a frame
HDR0, 8'hEB, first header byte
HDR1, 8'h90, second header byte

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
RXRDY  input  1  COREUART RX data available
RX_DATA  input  8  COREUART DATA_OUT
OEN  output  1  COREUART read strobe, active low
CMD_DATA  output  8  payload byte to consumer
CMD_VALID  output  1  CMD_DATA valid
CMD_LAST  output  1  marks final payload byte
CMD_READY  input  1  consumer accepts byte
CMD_LEN  output  8  payload length of the frame being drained
FRAME_OK  output  1  1-cycle pulse, frame validated
CSUM_ERR  output  1  1-cycle pulse, checksum mismatch
FMT_ERR  output  1  1-cycle pulse, LEN = 0 or LEN > MAX_LEN
TMO_ERR  output  1  1-cycle pulse, inter-byte timeout
BUSY  output  1  high in any state other than HUNT1

Behaviour:
- Reset (async, high): state HUNT1; OEN=1; CMD_VALID=0; CMD_LAST=0; CMD_DATA=0; CMD_LEN=0; all error/OK pulses 0; BUSY=0; counters 0. Buffer contents are undefined. Reset mid-frame or mid-drain discards the frame; no pulse is emitted.
- Byte fetch: allowed only in HUNT1, HUNT2, LEN, PAYLOAD and CSUM.
  - Cycle T: RXRDY=1 and fetch idle -> OEN=0 for exactly one cycle.
  - Cycle T+1: RX_DATA is captured.
  - Cycle T+2: holdoff, OEN stays 1.
  - Earliest next OEN is T+3, so the maximum rate is 1 byte per 3 cycles.
  - OEN is never asserted in DRAIN, so the UART FIFO absorbs back-pressure.
- Frame format: HDR0, HDR1, LEN, LEN payload bytes, CSUM. CSUM = (LEN + sum of payload) mod 256.
- State transitions on each captured byte b:
  - HUNT1: b==HDR0 -> HUNT2; else stay.
  - HUNT2: b==HDR1 -> LEN; b==HDR0 -> stay HUNT2; else -> HUNT1.
  - LEN: 1<=b<=MAX_LEN -> PAYLOAD; store LEN; sum=b; idx=0. Otherwise FMT_ERR pulse and -> HUNT1.
  - PAYLOAD: buf[idx]=b; sum+=b (8-bit wrap); idx++; when idx reaches LEN -> CSUM.
  - CSUM: b==sum -> FRAME_OK pulse; CMD_LEN=LEN; idx=0; -> DRAIN. Else CSUM_ERR pulse and -> HUNT1.
- Pulses are asserted the cycle after the capture cycle.
- DRAIN:
  - CMD_VALID=1, CMD_DATA=buf[idx], CMD_LAST=(idx==CMD_LEN-1).
  - Each cycle with CMD_VALID&CMD_READY: idx++.
  - Transfer with CMD_LAST -> CMD_VALID=0 the next cycle, -> HUNT1.
  - CMD_DATA, CMD_LAST and CMD_LEN stay stable while VALID&!READY.
- Timeout:
  - Counter runs in LEN, PAYLOAD and CSUM; it clears on each captured byte and on state entry.
  - Count reaching TIMEOUT_CYC-1 -> TMO_ERR pulse, -> HUNT1.
  - The counter does not run in HUNT1, HUNT2 or DRAIN.
- Simultaneous events: timeout expiry and a byte capture in the same cycle -> the capture wins and the counter clears.
- Width rules:
  - idx uses clog2(MAX_LEN+1) bits.
  - Timeout counter uses clog2(TIMEOUT_CYC) bits.
  - sum is 8 bits modulo 256.

Test Plan:
- Clean frame: feed EB 90 03 11 22 33 69 with CMD_READY=1 -> FRAME_OK once; CMD_LEN=3; stream 11,22,33 with CMD_LAST on 33; each OEN low pulse is exactly 1 cycle, spaced >=3 cycles apart.
- Bad checksum: feed EB 90 02 01 02 04 -> CSUM_ERR pulse; CMD_VALID never high; next valid frame is accepted normally.
- Header resync: feed 00 EB EB 90 01 55 56 -> frame accepted with payload 55; feed EB 90 00 -> FMT_ERR; feed EB 90 21 (MAX_LEN=32) -> FMT_ERR.
- Timeout: feed EB 90 04 AA, then idle TIMEOUT_CYC cycles -> TMO_ERR pulse exactly at expiry, BUSY drops; a following frame is parsed correctly.
- Back-pressure: a 32-byte frame with 0xFF payload (CSUM=0xE0+0x20=0x00) and CMD_READY toggling 1-0 -> CMD_DATA stable while stalled; OEN stays high throughout DRAIN even with RXRDY=1; all 32 bytes are delivered in order.
- Async reset asserted mid-PAYLOAD and mid-DRAIN -> all outputs take reset values immediately; no FRAME_OK or error pulse follows.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: pops bytes from a COREUART RX FIFO, hunts a two-byte header, buffers a
// length-prefixed payload and streams it to the consumer only when its checksum matches.
module uart_frame_rx #(
    parameter int         MAX_LEN     = 32,
    parameter int         TIMEOUT_CYC = 40000,
    parameter logic [7:0] HDR0        = 8'hEB,
    parameter logic [7:0] HDR1        = 8'h90
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXRDY,
    input  logic [7:0] RX_DATA,
    output logic       OEN,
    output logic [7:0] CMD_DATA,
    output logic       CMD_VALID,
    output logic       CMD_LAST,
    input  logic       CMD_READY,
    output logic [7:0] CMD_LEN,
    output logic       FRAME_OK,
    output logic       CSUM_ERR,
    output logic       FMT_ERR,
    output logic       TMO_ERR,
    output logic       BUSY
);
    // state   | meaning
    // HUNT1   | waiting for HDR0
    // HUNT2   | HDR0 seen, waiting for HDR1
    // LEN     | waiting for the length byte
    // PAYLOAD | collecting LEN bytes into the buffer
    // CSUM    | waiting for the checksum byte
    // DRAIN   | streaming the validated payload, UART fetch paused

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [TW-1:0] TC_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_HUNT1, S_HUNT2, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN
    } state_t;

    // Fetch handshake: strobe OEN, capture on the following cycle, then one holdoff cycle.
    typedef enum logic [1:0] {
        F_IDLE, F_STB, F_CAP, F_HOLD
    } fetch_t;

    state_t         state_q, state_d;
    fetch_t         fph_q, fph_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [7:0]     len_q, len_d;
    logic [7:0]     sum_q, sum_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [7:0]     cmd_len_q, cmd_len_d;
    logic           ok_q, ok_d;
    logic           cerr_q, cerr_d;
    logic           ferr_q, ferr_d;
    logic           terr_q, terr_d;
    logic           cap, fetch_ok, tmo_run, wr_en, last_beat;
    logic [7:0]     mem_q [2**BW];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_HUNT1;
            fph_q     <= F_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            tcnt_q    <= '0;
            cmd_len_q <= '0;
            ok_q      <= 1'b0;
            cerr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fph_q     <= fph_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            tcnt_q    <= tcnt_d;
            cmd_len_q <= cmd_len_d;
            ok_q      <= ok_d;
            cerr_q    <= cerr_d;
            ferr_q    <= ferr_d;
            terr_q    <= terr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[idx_q[BW-1:0]] <= RX_DATA;
    end

    assign last_beat = (9'(idx_q) + 9'd1) == {1'b0, cmd_len_q};

    always_comb begin
        state_d   = state_q;
        fph_d     = fph_q;
        idx_d     = idx_q;
        len_d     = len_q;
        sum_d     = sum_q;
        tcnt_d    = tcnt_q;
        cmd_len_d = cmd_len_q;
        ok_d      = 1'b0;
        cerr_d    = 1'b0;
        ferr_d    = 1'b0;
        terr_d    = 1'b0;
        wr_en     = 1'b0;
        fetch_ok  = (state_q != S_DRAIN);
        cap       = (fph_q == F_CAP);
        tmo_run   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);

        case (fph_q)
            F_IDLE:  if (fetch_ok && RXRDY) fph_d = F_STB;
            F_STB:   fph_d = F_CAP;
            F_CAP:   fph_d = F_HOLD;
            default: fph_d = (fetch_ok && RXRDY) ? F_STB : F_IDLE;
        endcase

        case (state_q)
            S_HUNT1: if (cap && RX_DATA == HDR0) state_d = S_HUNT2;
            S_HUNT2: begin
                if (cap) begin
                    if (RX_DATA == HDR1)      state_d = S_LEN;
                    else if (RX_DATA != HDR0) state_d = S_HUNT1;
                end
            end
            S_LEN: begin
                if (cap) begin
                    if (RX_DATA != 8'd0 && {1'b0, RX_DATA} <= MAX_LEN_W) begin
                        len_d   = RX_DATA;
                        sum_d   = RX_DATA;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_HUNT1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (cap) begin
                    wr_en = 1'b1;
                    sum_d = sum_q + RX_DATA;
                    idx_d = idx_q + 1'b1;
                    if ((9'(idx_q) + 9'd1) == {1'b0, len_q}) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (cap) begin
                    if (RX_DATA == sum_q) begin
                        ok_d      = 1'b1;
                        cmd_len_d = len_q;
                        idx_d     = '0;
                        state_d   = S_DRAIN;
                    end else begin
                        cerr_d  = 1'b1;
                        state_d = S_HUNT1;
                    end
                end
            end
            default: begin
                if (CMD_READY) begin
                    if (last_beat) begin
                        idx_d   = '0;
                        state_d = S_HUNT1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase

        // A capture in the expiry cycle wins: the counter simply clears.
        if (!tmo_run || cap || (state_d != state_q)) begin
            tcnt_d = '0;
        end else if (tcnt_q == TC_LAST) begin
            terr_d  = 1'b1;
            state_d = S_HUNT1;
            tcnt_d  = '0;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    assign OEN       = (fph_q != F_STB);
    assign CMD_VALID = (state_q == S_DRAIN);
    assign CMD_DATA  = CMD_VALID ? mem_q[idx_q[BW-1:0]] : 8'h00;
    assign CMD_LAST  = CMD_VALID && last_beat;
    assign CMD_LEN   = cmd_len_q;
    assign FRAME_OK  = ok_q;
    assign CSUM_ERR  = cerr_q;
    assign FMT_ERR   = ferr_q;
    assign TMO_ERR   = terr_q;
    assign BUSY      = (state_q != S_HUNT1);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: a FIFO model feeds byte streams, a frame-level reference parser
// predicts events and delivered payload; table vectors, random streams and reset corners.
`timescale 1ns/1ps
module tb_uart_frame_rx;
    localparam int MAX_LEN = 32;
    localparam int TC      = 40;

    typedef logic [7:0] bq_t [$];
    typedef int iq_t [$];
    typedef struct {
        logic [7:0] b [48];
        int nb;
        int rdy;
        int ok;
        int cs;
        int fm;
        int tm;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       RXRDY = 1'b0;
    logic [7:0] RX_DATA = 8'h00;
    logic       CMD_READY = 1'b1;
    logic       OEN, CMD_VALID, CMD_LAST, FRAME_OK, CSUM_ERR, FMT_ERR, TMO_ERR, BUSY;
    logic [7:0] CMD_DATA, CMD_LEN;

    uart_frame_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TC), .HDR0(8'hEB), .HDR1(8'h90)) dut (
        .CLK(CLK), .RESET(RESET), .RXRDY(RXRDY), .RX_DATA(RX_DATA), .OEN(OEN),
        .CMD_DATA(CMD_DATA), .CMD_VALID(CMD_VALID), .CMD_LAST(CMD_LAST), .CMD_READY(CMD_READY),
        .CMD_LEN(CMD_LEN), .FRAME_OK(FRAME_OK), .CSUM_ERR(CSUM_ERR), .FMT_ERR(FMT_ERR),
        .TMO_ERR(TMO_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Observation state, written by the monitor and cleared between scenarios.
    logic [7:0] fifo [$];
    int         rdy_mode = 0;
    int         cyc = 0;
    int         n_ok, n_cs, n_fm, n_tm, n_strobe;
    logic [7:0] got_q [$];
    logic [7:0] got_last [$];
    int         got_len [$];
    int         last_strobe = -100;
    bit         oen_prev_low = 0;
    bit         stall_prev = 0;
    logic [7:0] stall_data, stall_len;
    logic       stall_last;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RESET) begin
            stall_prev   = 0;
            oen_prev_low = 0;
        end else begin
            if (FRAME_OK) begin
                n_ok++;
                got_len.push_back(int'(CMD_LEN));
            end
            if (CSUM_ERR) n_cs++;
            if (FMT_ERR) n_fm++;
            if (TMO_ERR) begin
                n_tm++;
                check("tmo_cycle", cyc, last_strobe + 2 + TC);
                check("tmo_busy", BUSY, 0);
            end
            if (!OEN) begin
                n_strobe++;
                check("oen_width", oen_prev_low, 0);
                check("oen_spacing", (cyc - last_strobe) >= 3, 1);
                last_strobe = cyc;
                check("oen_with_data", fifo.size() > 0, 1);
                if (fifo.size() > 0) RX_DATA = fifo.pop_front();
            end
            oen_prev_low = !OEN;
            if (CMD_VALID) check("oen_in_drain", OEN, 1);
            if (stall_prev) begin
                check("stall_valid", CMD_VALID, 1);
                check("stall_data", CMD_DATA, stall_data);
                check("stall_last", CMD_LAST, stall_last);
                check("stall_len", CMD_LEN, stall_len);
            end
            case (rdy_mode)
                0:       CMD_READY = 1'b1;
                1:       CMD_READY = !CMD_READY;
                2:       CMD_READY = 1'($urandom_range(0, 1));
                default: CMD_READY = 1'b0;
            endcase
            if (CMD_VALID && CMD_READY) begin
                got_q.push_back(CMD_DATA);
                got_last.push_back({7'd0, CMD_LAST});
            end
            stall_prev = CMD_VALID && !CMD_READY;
            stall_data = CMD_DATA;
            stall_last = CMD_LAST;
            stall_len  = CMD_LEN;
        end
        RXRDY = (fifo.size() != 0);
    end

    // Frame-level reference: locate "HDR0 HDR1" pairs, then apply length and checksum rules.
    function automatic void model(input bq_t s, output int ok, output int cs, output int fm,
                                  output int tm, output bq_t pay, output bq_t last,
                                  output iq_t lens);
        int i, n, L;
        logic [7:0] sum;
        ok = 0; cs = 0; fm = 0; tm = 0;
        pay = {}; last = {}; lens = {};
        n = s.size();
        i = 0;
        while (i + 1 < n) begin
            if (s[i] == 8'hEB && s[i+1] == 8'h90) begin
                if (i + 2 >= n) begin tm++; break; end
                L = int'(s[i+2]);
                if (L == 0 || L > MAX_LEN) begin
                    fm++;
                    i += 3;
                    continue;
                end
                if (i + 3 + L >= n) begin tm++; break; end
                sum = 8'(L);
                for (int k = 0; k < L; k++) sum = sum + s[i+3+k];
                if (sum == s[i+3+L]) begin
                    ok++;
                    lens.push_back(L);
                    for (int k = 0; k < L; k++) begin
                        pay.push_back(s[i+3+k]);
                        last.push_back((k == L - 1) ? 8'd1 : 8'd0);
                    end
                end else begin
                    cs++;
                end
                i += 4 + L;
            end else begin
                i++;
            end
        end
    endfunction

    function automatic bq_t gen_frame(input int L, input bit good);
        bq_t f;
        logic [7:0] sum, b;
        f = '{8'hEB, 8'h90};
        f.push_back(8'(L));
        sum = 8'(L);
        for (int k = 0; k < L; k++) begin
            b = 8'($urandom_range(0, 255));
            sum = sum + b;
            f.push_back(b);
        end
        f.push_back(good ? sum : sum + 8'($urandom_range(1, 255)));
        return f;
    endfunction

    task automatic clear_obs();
        n_ok = 0; n_cs = 0; n_fm = 0; n_tm = 0; n_strobe = 0;
        got_q = {}; got_last = {}; got_len = {};
    endtask

    task automatic wait_idle(input string tag);
        int stable = 0;
        for (int i = 0; i < 4000 && stable < 8; i++) begin
            @(negedge CLK); #1;
            if (fifo.size() == 0 && !BUSY && OEN) stable++;
            else stable = 0;
        end
        check({tag, "_idle"}, stable >= 8, 1);
    endtask

    task automatic run_stream(input string tag, input bq_t s, input int rdy);
        clear_obs();
        rdy_mode = rdy;
        foreach (s[k]) fifo.push_back(s[k]);
        wait_idle(tag);
    endtask

    task automatic compare(input string tag, input int ok, input int cs, input int fm,
                           input int tm, input bq_t pay, input bq_t last, input iq_t lens);
        check({tag, "_frame_ok"}, n_ok, ok);
        check({tag, "_csum_err"}, n_cs, cs);
        check({tag, "_fmt_err"}, n_fm, fm);
        check({tag, "_tmo_err"}, n_tm, tm);
        check({tag, "_nbytes"}, got_q.size(), pay.size());
        for (int k = 0; k < pay.size() && k < got_q.size(); k++) begin
            check({tag, "_data"}, got_q[k], pay[k]);
            check({tag, "_last"}, got_last[k], last[k]);
        end
        for (int k = 0; k < lens.size() && k < got_len.size(); k++)
            check({tag, "_cmd_len"}, got_len[k], lens[k]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oen"}, OEN, 1);
        check({tag, "_valid"}, CMD_VALID, 0);
        check({tag, "_last"}, CMD_LAST, 0);
        check({tag, "_data"}, CMD_DATA, 0);
        check({tag, "_len"}, CMD_LEN, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_pulses"}, {FRAME_OK, CSUM_ERR, FMT_ERR, TMO_ERR}, 0);
    endtask

    task automatic add_vec(inout vec_t vq [$], input bq_t s, input int rdy, input int ok,
                           input int cs, input int fm, input int tm);
        vec_t v;
        v.nb = s.size();
        for (int k = 0; k < 48; k++) v.b[k] = (k < v.nb) ? s[k] : 8'h00;
        v.rdy = rdy; v.ok = ok; v.cs = cs; v.fm = fm; v.tm = tm;
        vq.push_back(v);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [$];
        bq_t  s, f, mpay, mlast;
        iq_t  mlens;
        int   mok, mcs, mfm, mtm, nitems, L;
        logic [7:0] b;

        // Table: stream, ready mode (0 always, 1 toggle, 2 random), expected ok/csum/fmt/tmo.
        add_vec(vecs, '{8'hEB, 8'h90, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 0, 1, 0, 0, 0);
        add_vec(vecs, '{8'hEB, 8'h90, 8'h02, 8'h01, 8'h02, 8'h04}, 0, 0, 1, 0, 0);
        add_vec(vecs, '{8'hEB, 8'h90, 8'h01, 8'h7E, 8'h7F}, 0, 1, 0, 0, 0);
        add_vec(vecs, '{8'h00, 8'hEB, 8'hEB, 8'h90, 8'h01, 8'h55, 8'h56}, 0, 1, 0, 0, 0);
        add_vec(vecs, '{8'hEB, 8'h90, 8'h00}, 0, 0, 0, 1, 0);
        add_vec(vecs, '{8'hEB, 8'h90, 8'h21}, 0, 0, 0, 1, 0);
        s = '{8'hEB, 8'h90, 8'h20};
        repeat (32) s.push_back(8'hFF);
        s.push_back(8'h00);
        add_vec(vecs, s, 1, 1, 0, 0, 0);
        add_vec(vecs, '{8'hEB, 8'h90, 8'h04, 8'hAA}, 0, 0, 0, 0, 1);
        add_vec(vecs, '{8'hEB, 8'h90, 8'h02, 8'h10, 8'h20, 8'h32}, 0, 1, 0, 0, 0);
        add_vec(vecs, '{8'hEB, 8'h90, 8'h01, 8'h00, 8'h01, 8'hEB, 8'h90, 8'h02,
                        8'hFF, 8'h01, 8'h02}, 2, 2, 0, 0, 0);

        clear_obs();
        repeat (3) @(negedge CLK);
        #1 check_reset_outputs("reset");
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        for (int v = 0; v < vecs.size(); v++) begin
            s = {};
            for (int k = 0; k < vecs[v].nb; k++) s.push_back(vecs[v].b[k]);
            model(s, mok, mcs, mfm, mtm, mpay, mlast, mlens);
            run_stream($sformatf("vec%0d", v), s, vecs[v].rdy);
            compare($sformatf("vec%0d", v), vecs[v].ok, vecs[v].cs, vecs[v].fm, vecs[v].tm,
                    mpay, mlast, mlens);
        end

        // Reset in the middle of a payload: nothing may be reported afterwards.
        clear_obs();
        rdy_mode = 0;
        s = '{8'hEB, 8'h90, 8'h05, 8'h01, 8'h02, 8'h03};
        foreach (s[k]) fifo.push_back(s[k]);
        for (int i = 0; i < 200 && n_strobe < 5; i++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        #1 check("rstA_pre_busy", BUSY, 1);
        #2 RESET = 1'b1;
        #1 check_reset_outputs("rstA");
        fifo.delete();
        clear_obs();
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (TC + 20) @(negedge CLK);
        #1;
        check("rstA_pulses", n_ok + n_cs + n_fm + n_tm, 0);
        check("rstA_busy", BUSY, 0);

        // Stalled drain with more bytes waiting in the FIFO, then reset mid-drain.
        clear_obs();
        rdy_mode = 3;
        s = '{8'hEB, 8'h90, 8'h02, 8'h10, 8'h20, 8'h32};
        foreach (s[k]) fifo.push_back(s[k]);
        for (int i = 0; i < 300 && !CMD_VALID; i++) begin @(negedge CLK); #1; end
        check("rstB_valid", CMD_VALID, 1);
        s = '{8'hEB, 8'h90, 8'h01, 8'h05, 8'h06};
        foreach (s[k]) fifo.push_back(s[k]);
        repeat (6) @(negedge CLK);
        #1;
        check("rstB_ok", n_ok, 1);
        check("rstB_data", CMD_DATA, 8'h10);
        check("rstB_last", CMD_LAST, 0);
        check("rstB_len", CMD_LEN, 2);
        check("rstB_fifo_held", fifo.size(), 5);
        #2 RESET = 1'b1;
        #1 check_reset_outputs("rstB");
        fifo.delete();
        clear_obs();
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        rdy_mode = 0;
        repeat (TC + 20) @(negedge CLK);
        #1;
        check("rstB_pulses", n_ok + n_cs + n_fm + n_tm, 0);
        check("rstB_bytes", got_q.size(), 0);

        // Random streams of good, corrupt, malformed frames and junk.
        for (int r = 0; r < 10; r++) begin
            s = {};
            nitems = $urandom_range(3, 6);
            for (int it = 0; it < nitems; it++) begin
                case ($urandom_range(0, 5))
                    0: begin
                        b = 8'($urandom_range(0, 255));
                        if (b == 8'hEB) b = 8'h00;
                        s.push_back(b);
                    end
                    4: begin
                        f = gen_frame($urandom_range(1, MAX_LEN), 1'b0);
                        foreach (f[k]) s.push_back(f[k]);
                    end
                    5: begin
                        L = $urandom_range(0, 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                        s.push_back(8'hEB);
                        s.push_back(8'h90);
                        s.push_back(8'(L));
                    end
                    default: begin
                        f = gen_frame($urandom_range(1, MAX_LEN), 1'b1);
                        foreach (f[k]) s.push_back(f[k]);
                    end
                endcase
            end
            model(s, mok, mcs, mfm, mtm, mpay, mlast, mlens);
            run_stream($sformatf("rnd%0d", r), s, $urandom_range(0, 2));
            compare($sformatf("rnd%0d", r), mok, mcs, mfm, mtm, mpay, mlast, mlens);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
